// File: rtl/shared_memory_controller_pkg.sv
// Address map and shared types for the shared memory controller.
package shared_memory_controller_pkg;

    localparam logic [15:0] SHARED_BASE      = 16'h4000;
    localparam logic [15:0] SHARED_LIMIT     = 16'hBFFF;
    localparam logic [15:0] SEM_BASE         = 16'hFFF0;
    localparam logic [15:0] CYCLE_COUNT_ADDR = 16'hFFF8;

    typedef enum logic [1:0] {RegReserved, RegRam, RegSem, RegCount} region_e;

    // Which register drives read_val: the RAM output register or the held value.
    typedef enum logic {SrcHold, SrcRam} rd_src_e;

    function automatic region_e decode_region(input logic [15:0]   addr,
                                              input int unsigned   num_sem);
        region_e r;
        if (addr >= SHARED_BASE && addr <= SHARED_LIMIT) begin
            r = RegRam;
        end else if (addr >= SEM_BASE && {16'h0, addr - SEM_BASE} < num_sem) begin
            r = RegSem;
        end else if (addr == CYCLE_COUNT_ADDR) begin
            r = RegCount;
        end else begin
            r = RegReserved;
        end
        return r;
    endfunction

endpackage

// File: rtl/shared_memory_controller_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_i,
    input  logic                 advance_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] grant_idx_o
);
    localparam int unsigned IdxW = $clog2(N);

    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] idx;
    logic            found;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = rr_ptr_q;
        found       = 1'b0;
        idx         = rr_ptr_q;
        for (int unsigned i = 0; i < N; i++) begin
            idx = IdxW'((32'(rr_ptr_q) + i) % N);
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_idx_o = idx;
            end
        end
        if (found && !reset) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

    // Kept separate from the grant logic so advance_i (derived from grant_o) forms no loop.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance_i) begin
            rr_ptr_d = (grant_idx_o == IdxW'(N - 1)) ? '0 : grant_idx_o + IdxW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/shared_memory_controller.sv
// Shared memory controller: round-robin access from several cores to shared RAM,
// test-and-set semaphores and a free-running cycle counter.
module shared_memory_controller
    import shared_memory_controller_pkg::*;
#(
    parameter int unsigned NUM_CORES          = 2,
    parameter int unsigned SHARED_MEMORY_SIZE = 16384,
    parameter int unsigned NUM_SEMAPHORES     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CORES-1:0]    core_request_i,
    input  logic [16*NUM_CORES-1:0] core_addr_i,
    input  logic [NUM_CORES-1:0]    core_wren_i,
    input  logic [NUM_CORES-1:0]    core_rden_i,
    input  logic [16*NUM_CORES-1:0] core_write_val_i,
    output logic [NUM_CORES-1:0]    core_enable_o,
    output logic [15:0]             read_val_o
);
    localparam int unsigned IdxW  = $clog2(NUM_CORES);
    localparam int unsigned RamAw = $clog2(SHARED_MEMORY_SIZE);

    logic [NUM_CORES-1:0]      grant;
    logic [IdxW-1:0]           gnt_idx;
    logic                      gnt_any;
    logic [15:0]               acc_addr, acc_wdata;
    logic                      acc_wren, acc_rden;
    region_e                   region;
    logic [2:0]                sem_idx;
    logic                      ram_we, ram_re;
    logic [15:0]               ram_q [SHARED_MEMORY_SIZE];
    logic [15:0]               ram_rdata_q;
    logic [NUM_SEMAPHORES-1:0] sem_q, sem_d;
    logic [15:0]               count_q, count_d;
    logic [15:0]               rd_hold_q, rd_hold_d;
    rd_src_e                   rd_src_q, rd_src_d;

    rr_arbiter #(
        .N(NUM_CORES)
    ) u_arbiter (
        .clk        (clk),
        .reset      (reset),
        .req_i      (core_request_i),
        .advance_i  (gnt_any),
        .grant_o    (grant),
        .grant_idx_o(gnt_idx)
    );

    assign gnt_any       = |grant;
    assign core_enable_o = grant;

    always_comb begin
        acc_addr  = '0;
        acc_wdata = '0;
        acc_wren  = 1'b0;
        acc_rden  = 1'b0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (gnt_idx == IdxW'(i)) begin
                acc_addr  = core_addr_i[16*i +: 16];
                acc_wdata = core_write_val_i[16*i +: 16];
                acc_wren  = core_wren_i[i];
                acc_rden  = core_rden_i[i];
            end
        end
    end

    assign region  = decode_region(acc_addr, NUM_SEMAPHORES);
    assign sem_idx = acc_addr[2:0];

    // A write wins over a simultaneous read, so the RAM read port only sees pure reads.
    assign ram_we = gnt_any && acc_wren && (region == RegRam);
    assign ram_re = gnt_any && acc_rden && !acc_wren && (region == RegRam);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_q[acc_addr[RamAw-1:0]] <= acc_wdata;
        end
        if (ram_re) begin
            ram_rdata_q <= ram_q[acc_addr[RamAw-1:0]];
        end
    end

    always_comb begin
        sem_d     = sem_q;
        count_d   = count_q + 16'd1;
        rd_src_d  = rd_src_q;
        rd_hold_d = rd_hold_q;
        if (gnt_any && acc_wren) begin
            rd_src_d  = SrcHold;
            rd_hold_d = '0;
            if (region == RegSem) begin
                sem_d[sem_idx] = acc_wdata[0];
            end
        end else if (gnt_any && acc_rden) begin
            rd_src_d  = SrcHold;
            rd_hold_d = '0;
            case (region)
                RegRam:   rd_src_d = SrcRam;
                RegSem: begin
                    rd_hold_d      = {15'h0, sem_q[sem_idx]};
                    sem_d[sem_idx] = 1'b1;
                end
                RegCount: rd_hold_d = count_q;
                default:  rd_hold_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sem_q     <= '0;
            count_q   <= '0;
            rd_src_q  <= SrcHold;
            rd_hold_q <= '0;
        end else begin
            sem_q     <= sem_d;
            count_q   <= count_d;
            rd_src_q  <= rd_src_d;
            rd_hold_q <= rd_hold_d;
        end
    end

    assign read_val_o = (rd_src_q == SrcRam) ? ram_rdata_q : rd_hold_q;

endmodule

// File: tb/tb_shared_memory_controller.sv
// Scoreboard bench for shared_memory_controller: directed scenarios plus randomized traffic.
module tb_shared_memory_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  core_request = '0;
    logic [31:0] core_addr = '0;
    logic [1:0]  core_wren = '0;
    logic [1:0]  core_rden = '0;
    logic [31:0] core_write_val = '0;
    logic [1:0]  core_enable;
    logic [15:0] read_val;

    always #5 clk = ~clk;

    shared_memory_controller #(
        .NUM_CORES         (2),
        .SHARED_MEMORY_SIZE(16384),
        .NUM_SEMAPHORES    (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .core_request_i  (core_request),
        .core_addr_i     (core_addr),
        .core_wren_i     (core_wren),
        .core_rden_i     (core_rden),
        .core_write_val_i(core_write_val),
        .core_enable_o   (core_enable),
        .read_val_o      (read_val)
    );

    // Reference model state
    logic [15:0] m_ram [int];
    bit          m_sem [8];
    int          m_rr;
    int unsigned m_cnt;
    logic [15:0] m_last;

    logic [1:0]  grant_q [$];
    logic [15:0] rv_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    bit          done = 1'b0;

    // Pending (possibly stalled) request per core for the random phase
    bit          pv [2];
    bit          pw [2];
    bit          pr [2];
    logic [15:0] pa [2];
    logic [15:0] pd [2];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // 1 = shared RAM, 2 = semaphore, 3 = cycle counter, 0 = reserved
    function automatic int region_of(input logic [15:0] a);
        if (a >= 16'h4000 && a <= 16'hBFFF) return 1;
        if (a >= 16'hFFF0 && a <= 16'hFFF7) return 2;
        if (a == 16'hFFF8) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_rr   = 0;
        m_cnt  = 0;
        m_last = '0;
        for (int k = 0; k < 8; k++) m_sem[k] = 1'b0;
    endtask

    // Drives one cycle of requests and pushes the model's expected grant / read_val.
    task automatic step(input logic [1:0] req, input logic [15:0] a0, input logic [15:0] a1,
                        input logic [1:0] wr, input logic [1:0] rd,
                        input logic [15:0] d0, input logic [15:0] d1, output int g);
        logic [15:0] a [2];
        logic [15:0] d [2];
        logic [15:0] rv;
        int          ix;
        @(negedge clk);
        core_request   = req;
        core_addr      = {a1, a0};
        core_wren      = wr;
        core_rden      = rd;
        core_write_val = {d1, d0};
        a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1;
        g = -1;
        for (int i = 0; i < 2; i++) begin
            int c;
            c = (m_rr + i) % 2;
            if (g < 0 && req[c]) g = c;
        end
        grant_q.push_back(g < 0 ? 2'b00 : 2'(1 << g));
        if (g >= 0) begin
            m_rr = (g + 1) % 2;
            rv   = m_last;
            ix   = int'(a[g][13:0]);
            if (wr[g]) begin
                rv = '0;
                case (region_of(a[g]))
                    1:       m_ram[ix] = d[g];
                    2:       m_sem[int'(a[g]) - 'hFFF0] = d[g][0];
                    default: ;
                endcase
            end else if (rd[g]) begin
                case (region_of(a[g]))
                    1:       rv = m_ram.exists(ix) ? m_ram[ix] : 16'hxxxx;
                    2: begin
                        rv = {15'h0, m_sem[int'(a[g]) - 'hFFF0]};
                        m_sem[int'(a[g]) - 'hFFF0] = 1'b1;
                    end
                    3:       rv = m_cnt[15:0];
                    default: rv = '0;
                endcase
            end
            m_last = rv;
            rv_q.push_back(rv);
        end
        m_cnt = (m_cnt + 1) % 65536;
    endtask

    task automatic idle();
        int g;
        step(2'b00, '0, '0, 2'b00, 2'b00, '0, '0, g);
    endtask

    task automatic gen_req(input int i);
        int kind, op;
        kind = int'($urandom_range(0, 9));
        if (kind < 5)
            pa[i] = 16'(($urandom_range(0, 1) != 0 ? 32'h8000 : 32'h4000)
                        + 32'h10 * $urandom_range(0, 7));
        else if (kind < 7) pa[i] = 16'hFFF0 + 16'($urandom_range(0, 7));
        else if (kind == 7) pa[i] = 16'hFFF8;
        else if (kind == 8) pa[i] = 16'hC000 + 16'($urandom_range(0, 16'h3FEF));
        else pa[i] = 16'hFFF9 + 16'($urandom_range(0, 6));
        op    = int'($urandom_range(0, 9));
        pw[i] = (op < 4) || (op == 8);
        pr[i] = (op >= 4) && (op < 9);
        // Avoid reading RAM words the model has never seen written
        if (region_of(pa[i]) == 1 && pr[i] && !pw[i] && !m_ram.exists(int'(pa[i][13:0]))) begin
            pw[i] = 1'b1;
            pr[i] = 1'b0;
        end
        pd[i] = 16'($urandom);
        pv[i] = 1'b1;
    endtask

    task automatic step_pending();
        int g;
        step({pv[1], pv[0]}, pa[0], pa[1], {pw[1] & pv[1], pw[0] & pv[0]},
             {pr[1] & pv[1], pr[0] & pv[0]}, pd[0], pd[1], g);
        if (g >= 0) pv[g] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b1;
        core_request   = 2'b11;
        core_rden      = 2'b11;
        core_wren      = 2'b00;
        core_addr      = {16'h4010, 16'h4010};
        model_reset();
        for (int k = 0; k < 3; k++) begin
            #2;
            check("enable_in_reset", {14'h0, core_enable}, 16'h0000);
            check("read_val_in_reset", read_val, 16'h0000);
            if (k < 2) @(negedge clk);
        end
        @(posedge clk);
        #3;
        reset        = 1'b0;
        core_request = 2'b00;
        core_rden    = 2'b00;
    endtask

    // Monitor: compares grant every cycle and read_val after every granted cycle.
    initial begin
        logic [1:0] eg;
        while (!done) begin
            @(negedge clk);
            #2;
            if (!reset && !done) begin
                if (grant_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL grant_q_empty: core_enable %b with no expected entry", core_enable);
                end else begin
                    eg = grant_q.pop_front();
                    check("core_enable", {14'h0, core_enable}, {14'h0, eg});
                    if (core_enable != 2'b00) begin
                        @(posedge clk);
                        #1;
                        if (rv_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL read_val_unexpected: got %h with no expected entry", read_val);
                        end else begin
                            check("read_val", read_val, rv_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached with %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        model_reset();
        for (int i = 0; i < 2; i++) pv[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_read_val", read_val, 16'h0000);
        check("reset_enable", {14'h0, core_enable}, 16'h0000);
        @(posedge clk);
        #3;
        reset = 1'b0;

        // Simultaneous requests: core0 first, core1 stalls one cycle
        step(2'b11, 16'h4010, 16'h4020, 2'b11, 2'b00, 16'h1234, 16'h5678, g);
        step(2'b10, 16'h4010, 16'h4020, 2'b10, 2'b00, 16'h1234, 16'h5678, g);
        // Write then read back
        step(2'b01, 16'h4010, '0, 2'b00, 2'b01, '0, '0, g);
        step(2'b10, '0, 16'h4020, 2'b00, 2'b10, '0, '0, g);
        // Semaphore contention
        step(2'b11, 16'hFFF0, 16'hFFF0, 2'b00, 2'b11, '0, '0, g);
        step(2'b10, 16'hFFF0, 16'hFFF0, 2'b00, 2'b10, '0, '0, g);
        step(2'b01, 16'hFFF0, '0, 2'b01, 2'b00, 16'h0000, '0, g);
        step(2'b01, 16'hFFF0, '0, 2'b00, 2'b01, '0, '0, g);
        // Reserved space, read+write together, and a strobe-less request
        step(2'b01, 16'hC123, '0, 2'b00, 2'b01, '0, '0, g);
        step(2'b10, '0, 16'hFFF9, 2'b10, 2'b00, '0, 16'hBEEF, g);
        step(2'b10, '0, 16'hFFF9, 2'b00, 2'b10, '0, '0, g);
        step(2'b01, 16'h4020, '0, 2'b01, 2'b01, 16'hAAAA, '0, g);
        step(2'b01, 16'h4010, '0, 2'b00, 2'b01, '0, '0, g);
        step(2'b10, '0, 16'h4020, 2'b00, 2'b00, '0, '0, g);
        idle();

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++)
                if (!pv[i] && $urandom_range(0, 9) < 6) gen_req(i);
            step_pending();
        end
        for (int n = 0; n < 4 && (pv[0] || pv[1]); n++) step_pending();

        // Reset right after a read grant discards its result
        step(2'b01, 16'h4010, '0, 2'b00, 2'b01, '0, '0, g);
        do_reset();
        step(2'b11, 16'hFFF0, 16'hFFF0, 2'b00, 2'b11, '0, '0, g);
        step(2'b10, 16'hFFF0, 16'hFFF0, 2'b00, 2'b10, '0, '0, g);
        // Counter read at cycle 5, then run to wrap and read 0
        while (m_cnt != 5) idle();
        step(2'b01, 16'hFFF8, '0, 2'b00, 2'b01, '0, '0, g);
        for (int n = 0; n < 65536 && m_cnt != 0; n++) idle();
        step(2'b10, '0, 16'hFFF8, 2'b00, 2'b10, '0, '0, g);
        step(2'b01, 16'hFFF8, '0, 2'b00, 2'b01, '0, '0, g);

        @(posedge clk);
        #3;
        done = 1'b1;
        check("grant_q_left", 16'(grant_q.size()), 16'h0000);
        check("rv_q_left", 16'(rv_q.size()), 16'h0000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
